// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 arbitrated output mux.
package mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Grant index width, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed priority with channel 0 highest.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  arb_mode_e         mode,
    output logic [NUM_CH-1:0] grant_onehot,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any
);

    logic [SEL_W:0] start;
    logic [SEL_W:0] cand;
    logic           found;

    // Scan NUM_CH candidates starting at 'start'; the extra bit keeps the wrap exact.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        start        = (mode == ARB_FIXED) ? '0 : {1'b0, ptr};
        for (int i = 0; i < NUM_CH; i++) begin
            cand = start + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(NUM_CH)) begin
                cand = cand - (SEL_W+1)'(NUM_CH);
            end
            if (!found && req[cand[SEL_W-1:0]]) begin
                found                          = 1'b1;
                grant_idx                      = cand[SEL_W-1:0];
                grant_onehot[cand[SEL_W-1:0]]  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrated mux with a single registered output stage.
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  NUM_CH = 4,
    localparam int SEL_W  = sel_w(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_mode,
    input  logic [NUM_CH-1:0]        i_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    output logic [NUM_CH-1:0]        o_ready,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    output logic [SEL_W-1:0]         o_sel,
    input  logic                     i_ready
);

    // Handshake: a word moves on any rising edge where valid and ready are both
    // high. Inputs: i_valid[k] & o_ready[k]. Output: o_valid & i_ready. Once
    // o_valid is high it holds with stable o_data/o_sel until accepted.

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  next_ptr;
    logic [NUM_CH-1:0] grant_onehot;
    logic [SEL_W-1:0]  grant_idx;
    logic              any;
    logic              ld;
    logic              xfer;
    logic [DATA_W-1:0] grant_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req          (i_valid),
        .ptr          (ptr),
        .mode         (arb_mode_e'(i_mode)),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any)
    );

    assign ld   = !o_valid || i_ready;
    assign xfer = ld && any;

    // Gated by reset so no channel sees an accept while the block is held in reset.
    assign o_ready = (i_rst_n && xfer) ? grant_onehot : '0;

    assign next_ptr = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

    // Only the granted channel's slice reaches the output register.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_onehot[k]) begin
                grant_data = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
            ptr     <= '0;
        end else if (ld) begin
            if (any) begin
                o_valid <= 1'b1;
                o_data  <= grant_data;
                o_sel   <= grant_idx;
                ptr     <= next_ptr;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: directed vector table, reset corners, then randomized traffic.
module tb_mux_arb_nto1;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int SW  = 2;

    logic              clk;
    logic              rst_n;
    logic              mode;
    logic [NCH-1:0]    valid;
    logic [NCH*DW-1:0] data;
    logic              rdy;
    logic [NCH-1:0]    o_ready;
    logic              o_valid;
    logic [DW-1:0]     o_data;
    logic [SW-1:0]     o_sel;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: words accepted by the mux and not yet delivered, as {sel, data}.
    logic [SW+DW-1:0] exp_q[$];
    int m_ptr;
    int seq[NCH];
    int out_seq[NCH];
    int wait_cnt[NCH];
    bit fair_on;
    bit sticky;

    typedef struct {
        logic           mode;
        logic [NCH-1:0] valid;
        logic           rdy;
        logic [NCH-1:0] exp_ready;
        logic           exp_ov;
        logic [SW-1:0]  exp_sel;
        logic [DW-1:0]  exp_data;
    } vec_t;

    vec_t vecs[16];

    mux_arb_nto1 #(
        .DATA_W (DW),
        .NUM_CH (NCH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mode  (mode),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .i_ready (rdy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant by the arbitration rule: first requester at or after the start point, wrapping.
    function automatic int model_grant(input logic [NCH-1:0] v, input int p, input logic fixed);
        int start;
        start = fixed ? 0 : p;
        for (int i = 0; i < NCH; i++) begin
            if (v[(start + i) % NCH]) return (start + i) % NCH;
        end
        return -1;
    endfunction

    task automatic set_data_fixed();
        for (int k = 0; k < NCH; k++) data[k*DW +: DW] = 32'hA0 + k;
    endtask

    task automatic set_data_seq();
        for (int k = 0; k < NCH; k++) data[k*DW +: DW] = {8'(k), 24'(seq[k])};
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_rand();
        rdy = ($urandom_range(0, 3) != 0);
        if (sticky) begin
            for (int k = 0; k < NCH; k++)
                if (!valid[k] && $urandom_range(0, 2) == 0) valid[k] = 1'b1;
        end else begin
            valid = NCH'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mode = ~mode;
        end
        set_data_seq();
    endtask

    // One clock of model prediction and comparison; inputs already driven.
    task automatic model_cycle();
        int             g;
        bit             ld;
        logic [NCH-1:0] er;
        logic [NCH-1:0] dut_r;
        logic [DW-1:0]  pre_data;
        logic [SW-1:0]  pre_sel;
        logic           pre_ov;
        #1;
        ld = (exp_q.size() == 0) || rdy;
        g  = model_grant(valid, m_ptr, mode);
        er = '0;
        if (ld && g >= 0) er[g] = 1'b1;
        chk("o_ready", 64'(o_ready), 64'(er));
        dut_r    = o_ready;
        pre_data = o_data;
        pre_sel  = o_sel;
        pre_ov   = o_valid;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0 && rdy) begin
            void'(exp_q.pop_front());
            if (pre_ov) begin
                chk($sformatf("order ch%0d", pre_sel), 64'(pre_data[23:0]), 64'(24'(out_seq[pre_sel])));
                out_seq[pre_sel]++;
            end
        end
        // Fairness from the grants the DUT actually issued.
        if (fair_on && dut_r != '0) begin
            for (int k = 0; k < NCH; k++) begin
                if (dut_r[k]) begin
                    chk($sformatf("rr_wait ch%0d", k), 64'(wait_cnt[k] > NCH), 64'(0));
                    wait_cnt[k] = 0;
                end else if (valid[k]) begin
                    wait_cnt[k]++;
                end
            end
        end
        if (ld && g >= 0) begin
            exp_q.push_back({SW'(g), data[g*DW +: DW]});
            m_ptr = (g + 1) % NCH;
            seq[g]++;
            if (sticky) valid[g] = 1'b0;
        end
        chk("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("o_data", 64'(o_data), 64'(exp_q[0][DW-1:0]));
            chk("o_sel", 64'(o_sel), 64'(exp_q[0][SW+DW-1:DW]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        vecs[5]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        vecs[6]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        vecs[7]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        vecs[8]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        vecs[9]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA0};
        vecs[11] = '{1'b0, 4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA2};
        vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
        vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
        vecs[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
        vecs[15] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};

        rst_n = 1'b0;
        mode  = 1'b0;
        valid = 4'b1111;
        rdy   = 1'b1;
        set_data_fixed();
        #1;
        chk("reset o_valid", 64'(o_valid), 64'(0));
        chk("reset o_data", 64'(o_data), 64'(0));
        chk("reset o_sel", 64'(o_sel), 64'(0));
        chk("reset o_ready", 64'(o_ready), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            mode  = vecs[i].mode;
            valid = vecs[i].valid;
            rdy   = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d o_ready", i), 64'(o_ready), 64'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d o_valid", i), 64'(o_valid), 64'(vecs[i].exp_ov));
            chk($sformatf("vec%0d o_sel", i), 64'(o_sel), 64'(vecs[i].exp_sel));
            chk($sformatf("vec%0d o_data", i), 64'(o_data), 64'(vecs[i].exp_data));
        end

        // Reset asserted in the middle of a stall
        rdy   = 1'b0;
        valid = 4'b1111;
        #1;
        chk("stall o_ready", 64'(o_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("stall o_data", 64'(o_data), 64'(32'hA3));
        chk("stall o_valid", 64'(o_valid), 64'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst o_valid", 64'(o_valid), 64'(0));
        chk("async rst o_data", 64'(o_data), 64'(0));
        chk("async rst o_sel", 64'(o_sel), 64'(0));
        chk("async rst o_ready", 64'(o_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("rst held o_ready", 64'(o_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        valid = 4'b0110;
        rdy   = 1'b1;
        mode  = 1'b0;
        #1;
        chk("post rst o_ready", 64'(o_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        chk("post rst o_sel", 64'(o_sel), 64'(1));
        chk("post rst o_data", 64'(o_data), 64'(32'hA1));
        chk("post rst o_valid", 64'(o_valid), 64'(1));

        // Randomized traffic against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        exp_q.delete();
        for (int k = 0; k < NCH; k++) begin
            seq[k]      = 0;
            out_seq[k]  = 0;
            wait_cnt[k] = 0;
        end
        mode    = 1'b0;
        sticky  = 1'b1;
        fair_on = 1'b1;
        drive_rand();
        for (int c = 0; c < 6000; c++) begin
            model_cycle();
            drive_rand();
        end
        sticky  = 1'b0;
        fair_on = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            model_cycle();
            drive_rand();
        end
        valid = '0;
        rdy   = 1'b1;
        repeat (3) model_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_nto1.md
MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

Interface
REQ-001 Parameter DATA_W, default 32, width of every data path.
REQ-002 Parameter NUM_CH, default 4, number of input channels; legal range 2..16.
REQ-003 Derived constant SEL_W = max(1, clog2(NUM_CH)), width of the grant index.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-007 i_valid  input  NUM_CH  per-channel request; bit k belongs to channel k.
REQ-008 i_data  input  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 o_ready  output  NUM_CH  per-channel accept, one-hot or zero.
REQ-010 o_valid  output  1  registered output holds a word.
REQ-011 o_data  output  DATA_W  registered selected word.
REQ-012 o_sel  output  SEL_W  index of the channel that supplied o_data.
REQ-013 i_ready  input  1  downstream accept.

Function
REQ-014 A transfer occurs on an input channel k when i_valid[k] and o_ready[k] are both high at a rising edge, and on the output when o_valid and i_ready are both high at a rising edge.
REQ-015 The load enable SHALL be ld = !o_valid || i_ready, which permits full throughput of one word per cycle.
REQ-016 o_ready[k] SHALL be high only when ld is high, i_valid has at least one bit set, and k is the granted channel; o_ready is combinational from i_valid, i_mode, i_ready and state.
REQ-017 In round-robin mode, the grant SHALL be the first set bit of i_valid found by scanning upward from the priority pointer ptr, wrapping from NUM_CH-1 to 0.
REQ-018 In fixed mode, the grant SHALL be the lowest-index set bit of i_valid.
REQ-019 On every input transfer from channel g, ptr SHALL become (g+1) mod NUM_CH in either mode; with no input transfer, ptr holds.
REQ-020 On an input transfer, o_data, o_sel and o_valid SHALL load the granted word, g and 1 respectively at the same edge, giving 1-cycle latency from input to output.
REQ-021 When ld is high and i_valid is 0, o_valid SHALL become 0; o_data and o_sel hold their last values.
REQ-022 When o_valid is 1 and i_ready is 0, o_valid, o_data and o_sel SHALL hold and every o_ready bit SHALL be 0 (stall, no data loss).
REQ-023 The block SHALL NOT observe i_data of non-granted channels, and a channel dropping i_valid before acceptance is legal and simply loses arbitration.
REQ-024 A change on i_mode SHALL take effect on the next arbitration decision; ptr is not reset by a mode change.
REQ-025 With NUM_CH=2, the scan SHALL wrap correctly, and a ptr value never reaches NUM_CH.

Reset
REQ-026 While i_rst_n is low, o_valid SHALL be 0, o_data 0, o_sel 0 and ptr 0, all asynchronously.
REQ-027 An assertion of reset during a stall SHALL discard the held word, and o_ready SHALL be 0 while reset is held.
REQ-028 The first arbitration after reset release SHALL use ptr = 0.

Structure
REQ-029 Package mux_pkg SHALL hold arb_mode_e (ARB_RR = 0, ARB_FIXED = 1) and the clog2-based SEL_W helper function.
REQ-030 The grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr, mode; outputs grant_onehot, grant_idx, any); mux_arb_nto1 instantiates it once and owns the output register and ptr.

Verification (NUM_CH=4, DATA_W=32)
REQ-031 Reset, then i_valid=4'b1111, data k=32'hA0+k, i_ready=1, RR mode -> o_sel sequence 0,1,2,3,0, one per cycle, o_data matching, o_valid continuous.
REQ-032 Fixed mode, i_valid=4'b1010 held, i_ready=1 -> channel 1 granted every cycle and channel 3 is never granted.
REQ-033 Output holds 32'hA2, i_ready=0 for 3 cycles with new requests pending -> o_data, o_sel and o_valid are stable and o_ready=0; when i_ready=1, the next grant loads on the same edge.
REQ-034 Only channel 3 valid, then only channel 0 valid -> grants 3 then 0 (ptr wraps 3->0).
REQ-035 i_rst_n is pulled low mid-stall with o_valid=1 -> o_valid=0, o_data=0 immediately, without a clock edge; after release, i_valid=4'b0110 -> first grant is 1.
REQ-036 Random valid/ready, 10k cycles, scoreboard -> per-channel order preserved, no loss or duplication, and in RR mode no channel waits more than NUM_CH grants.
